// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared geometry, types and column slicing for the 5x7 matrix scanner
package matrix_pkg;

    localparam int MTX_COLS   = 5;
    localparam int MTX_ROWS   = 7;
    localparam int MTX_PIXELS = 35;

    typedef logic [MTX_PIXELS-1:0] frame_t;
    typedef logic [2:0]            col_idx_t;
    typedef logic [MTX_ROWS-1:0]   row_t;

    // Pixel bit index is col*7 + row, so a column is a contiguous 7-bit slice.
    function automatic row_t col_slice(input frame_t f, input col_idx_t c);
        return f[c*MTX_ROWS +: MTX_ROWS];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - per-column dwell counter, tick at terminal count
module scan_prescaler #(
    parameter int SCAN_DIV = 50000,
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          tick,
    output logic [DW-1:0] div_cnt
);

    localparam logic [DW-1:0] TERM = DW'(SCAN_DIV - 1);

    assign tick = (div_cnt == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clr || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - double-buffered 5x7 column scanner; MATRIX_SCAN_BLANK_EN adds per-dwell blanking
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_en,
    input  logic [MTX_PIXELS-1:0] frame_in,
    input  logic                  frame_load,
    output logic                  frame_pending,
    output logic [MTX_COLS-1:0]   col_n,
    output logic [MTX_ROWS-1:0]   row_out,
    output logic                  frame_start
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam col_idx_t LAST_COL = col_idx_t'(MTX_COLS - 1);
`ifdef MATRIX_SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    frame_t   display;
    frame_t   pending;
    col_idx_t col_idx;
    logic     running;

    logic          tick;
    logic [DW-1:0] div_cnt;
    logic          scan_clr;

    logic     start;
    logic     advance;
    logic     wrap;
    logic     enter_col0;
    logic     swap;
    col_idx_t next_col;
    frame_t   next_display;
    logic [31:0] next_div;
    logic     blank;

    assign scan_clr = ~scan_en | ~running;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (scan_clr),
        .tick    (tick),
        .div_cnt (div_cnt)
    );

    // Outputs are registered, so everything is decided from next-state values.
    always_comb begin
        start        = scan_en & ~running;
        advance      = scan_en & running & tick;
        wrap         = advance && (col_idx == LAST_COL);
        enter_col0   = start | wrap;
        swap         = enter_col0 & frame_pending;
        next_col     = col_idx;
        if (start || wrap) begin
            next_col = '0;
        end else if (advance) begin
            next_col = col_idx + 3'd1;
        end
        next_display = swap ? pending : display;
        next_div     = (scan_clr || tick) ? 32'd0 : 32'(div_cnt) + 32'd1;
        blank        = BLANK_EN && (next_div < 32'(BLANK_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display       <= '0;
            pending       <= '0;
            frame_pending <= 1'b0;
            running       <= 1'b0;
            col_idx       <= '0;
            col_n         <= '1;
            row_out       <= '0;
            frame_start   <= 1'b0;
        end else begin
            // A load coinciding with a swap is captured after the swap reads the old frame.
            if (frame_load) begin
                pending <= frame_in;
            end
            frame_pending <= frame_load | (frame_pending & ~swap);
            display       <= next_display;

            if (!scan_en) begin
                running     <= 1'b0;
                col_idx     <= '0;
                col_n       <= '1;
                row_out     <= '0;
                frame_start <= 1'b0;
            end else begin
                running     <= 1'b1;
                col_idx     <= next_col;
                frame_start <= enter_col0;
                if (blank) begin
                    col_n   <= '1;
                    row_out <= '0;
                end else begin
                    col_n   <= ~(MTX_COLS'(1) << next_col);
                    row_out <= col_slice(next_display, next_col);
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - directed bench with a time-based scan model for matrix_scan_driver
module tb_matrix_scan_driver;

    localparam int SD  = 4;
    localparam int FRM = 5 * SD;
`ifdef MATRIX_SCAN_BLANK_EN
    localparam int BL = 1;
`else
    localparam int BL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_en = 1'b0;
    logic [34:0] frame_in = '0;
    logic        frame_load = 1'b0;
    logic        frame_pending;
    logic [4:0]  col_n;
    logic [6:0]  row_out;
    logic        frame_start;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    matrix_scan_driver #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scan_en       (scan_en),
        .frame_in      (frame_in),
        .frame_load    (frame_load),
        .frame_pending (frame_pending),
        .col_n         (col_n),
        .row_out       (row_out),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    // Model: position in the scan is just the cycle count since start.
    bit          m_run;
    int          m_cyc;
    logic [34:0] m_disp;
    logic [34:0] m_pend;
    bit          m_pf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_cyc = 0; m_disp = '0; m_pend = '0; m_pf = 0;
        end else begin
            if (!scan_en) begin
                m_run = 0;
            end else begin
                if (!m_run) begin
                    m_run = 1;
                    m_cyc = 0;
                end else begin
                    m_cyc = m_cyc + 1;
                end
                if ((m_cyc % FRM) == 0 && m_pf) begin
                    m_disp = m_pend;
                    m_pf   = 0;
                end
            end
            if (frame_load) begin
                m_pend = frame_in;
                m_pf   = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            logic [4:0] e_col;
            logic [6:0] e_row;
            logic       e_fs;
            e_col = 5'h1F;
            e_row = '0;
            e_fs  = 1'b0;
            if (m_run) begin
                int c;
                int ph;
                logic [34:0] sh;
                c  = (m_cyc / SD) % 5;
                ph = m_cyc % SD;
                e_fs = ((m_cyc % FRM) == 0);
                if (ph >= BL) begin
                    e_col = ~(5'd1 << c);
                    sh    = m_disp >> (7 * c);
                    e_row = sh[6:0];
                end
            end
            chk("model_col_n", 35'(col_n), 35'(e_col));
            chk("model_row_out", 35'(row_out), 35'(e_row));
            chk("model_frame_start", 35'(frame_start), 35'(e_fs));
            chk("model_frame_pending", 35'(frame_pending), 35'(m_pf));
        end
    end

    function automatic logic [6:0] lit0(input logic [6:0] v);
        return (BL > 0) ? 7'h00 : v;
    endfunction

    function automatic logic [4:0] col0();
        return (BL > 0) ? 5'h1F : 5'h1E;
    endfunction

    task automatic pulse_load(input logic [34:0] v);
        frame_in   = v;
        frame_load = 1'b1;
        @(negedge clk);
        frame_load = 1'b0;
    endtask

    task automatic wait_to(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_run && (m_cyc % FRM) == k) && n < 60);
        if (n >= 60) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_to: phase %0d not reached within 60 cycles", k);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_col_n", 35'(col_n), 35'h1F);
        chk("reset_row_out", 35'(row_out), 35'h0);
        chk("reset_frame_start", 35'(frame_start), 35'h0);
        chk("reset_pending", 35'(frame_pending), 35'h0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        pulse_load(35'h00000007F);
        chk("load_pending", 35'(frame_pending), 35'h1);
        scan_en = 1'b1;
        @(negedge clk);
        chk("start_col_n", 35'(col_n), 35'(col0()));
        chk("start_row_out", 35'(row_out), 35'(lit0(7'h7F)));
        chk("start_frame_start", 35'(frame_start), 35'h1);
        chk("start_pending_clear", 35'(frame_pending), 35'h0);
        wait_to(1);
        pulse_load(35'h0);
        wait_to(0);
        chk("frame_start_repeat", 35'(frame_start), 35'h1);

        wait_to(8);
        pulse_load(35'h7FFFFFFFF);
        chk("deferred_pending", 35'(frame_pending), 35'h1);
        chk("deferred_old_col2", 35'(row_out), 35'h0);
        wait_to(0);
        chk("deferred_new_row", 35'(row_out), 35'(lit0(7'h7F)));
        chk("deferred_pending_clear", 35'(frame_pending), 35'h0);

        wait_to(5);
        pulse_load(35'h000000011);
        wait_to(9);
        pulse_load(35'h012345678);
        wait_to(0);
        chk("overwrite_latest", 35'(row_out), 35'(lit0(7'h78)));

        wait_to(10);
        pulse_load(35'h00000003C);
        wait_to(19);
        pulse_load(35'h000000041);
        chk("coincident_old_frame", 35'(row_out), 35'(lit0(7'h3C)));
        chk("coincident_still_pending", 35'(frame_pending), 35'h1);
        wait_to(0);
        chk("coincident_next_frame", 35'(row_out), 35'(lit0(7'h41)));
        chk("coincident_pending_clear", 35'(frame_pending), 35'h0);

        wait_to(13);
        scan_en = 1'b0;
        @(negedge clk);
        chk("disable_col_n", 35'(col_n), 35'h1F);
        chk("disable_row_out", 35'(row_out), 35'h0);
        pulse_load(35'h000003FFF);
        repeat (2) @(negedge clk);
        scan_en = 1'b1;
        @(negedge clk);
        chk("reenable_frame_start", 35'(frame_start), 35'h1);
        chk("reenable_col_n", 35'(col_n), 35'(col0()));
        chk("reenable_row_out", 35'(row_out), 35'(lit0(7'h7F)));

        wait_to(6);
        pulse_load(35'h7FFFFFFFF);
        chk("prereset_pending", 35'(frame_pending), 35'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_col_n", 35'(col_n), 35'h1F);
        chk("async_row_out", 35'(row_out), 35'h0);
        chk("async_pending", 35'(frame_pending), 35'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postreset_row_out", 35'(row_out), 35'h0);
        chk("postreset_frame_start", 35'(frame_start), 35'h1);
        repeat (25) @(negedge clk);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
